// File: rtl/gpio_bus_pkg.sv
// Shared definitions for the GPIO word-to-byte bus bridge: FSM states, byte geometry
// and the byte-enable scan helper.
package gpio_bus_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NBYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_e;

    // Lowest enabled byte index at or above 'from'; returns NBYTES when none remain.
    function automatic logic [2:0] next_byte(input logic [3:0] be, input logic [2:0] from);
        logic [2:0] res;
        res = 3'(NBYTES);
        for (int i = NBYTES - 1; i >= 0; i--) begin
            if (be[i] && (3'(i) >= from)) begin
                res = 3'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Per-byte ready timeout: cleared while a byte is being set up, counts WAIT cycles and
// flags expiry on the TIMEOUT-th consecutive WAIT cycle without ready.
module bridge_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    assign expire = en && (cnt_q == LAST);

    // Wait-cycle counter; saturates at the expiry value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expire) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/gpio_bus_bridge.sv
// Word-to-byte bridge in front of the GPIO peripheral. One 32-bit CPU access is run as
// up to four LSB-first byte cycles with a ready handshake and per-byte timeout.
// Optional feature: define GPIO_BRIDGE_BE_EN to skip bytes whose cpu_be bit is clear.
module gpio_bus_bridge #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              cpu_busy,
    output logic              per_cs,
    output logic              per_wr,
    output logic              per_rd,
    output logic [ADDR_W-1:0] per_addr,
    output logic [7:0]        per_wdata,
    input  logic [7:0]        per_rdata,
    input  logic              per_ready
);

    import gpio_bus_pkg::*;

    localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [2:0]        gap_q, gap_d;
    logic              we_q, we_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [3:0]        be_sel;
    logic [2:0]        first, nxt;
    logic              tmo;

`ifdef GPIO_BRIDGE_BE_EN
    assign be_sel = cpu_be;
    logic unused_in;
    assign unused_in = ^cpu_addr[1:0];
`else
    assign be_sel = 4'hF;
    logic unused_in;
    assign unused_in = ^{cpu_be, cpu_addr[1:0]};
`endif

    bridge_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q == S_SETUP),
        .en    (state_q == S_WAIT),
        .expire(tmo)
    );

    // Next-state: accept, byte sequencing, read capture and timeout abort.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gap_d   = gap_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        first   = next_byte(be_sel, 3'd0);
        nxt     = next_byte(be_q, {1'b0, idx_q} + 3'd1);
        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr[ADDR_W-1:2];
                    wdata_d = cpu_wdata;
                    be_d    = be_sel;
                    err_d   = 1'b0;
                    if (first == 3'(NBYTES)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = first[1:0];
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: state_d = S_WAIT;
            S_WAIT: begin
                // Ready takes priority over a timeout landing on the same edge.
                if (per_ready) begin
                    if (!we_q) begin
                        rdata_d[BYTE_W*idx_q +: BYTE_W] = per_rdata;
                    end
                    if (nxt == 3'(NBYTES)) begin
                        state_d = S_DONE;
                    end else begin
                        gap_d   = '0;
                        state_d = S_GAP;
                    end
                end else if (tmo) begin
                    err_d = 1'b1;
                    // Bytes not yet received read back as zero after an abort.
                    if (!we_q) begin
                        for (int i = 0; i < NBYTES; i++) begin
                            if (i >= int'(idx_q)) begin
                                rdata_d[BYTE_W*i +: BYTE_W] = '0;
                            end
                        end
                    end
                    state_d = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    idx_d   = nxt[1:0];
                    state_d = S_SETUP;
                end else begin
                    gap_d = gap_q + 3'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and transfer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign per_cs    = (state_q == S_SETUP) || (state_q == S_WAIT);
    assign per_wr    = per_cs && we_q;
    assign per_rd    = per_cs && !we_q;
    assign per_addr  = {addr_q, idx_q};
    assign per_wdata = wdata_q[BYTE_W*idx_q +: BYTE_W];
    assign cpu_rdata = rdata_q;
    assign cpu_ack   = (state_q == S_DONE);
    assign cpu_err   = (state_q == S_DONE) && err_q;
    assign cpu_busy  = (state_q != S_IDLE);

endmodule
